// File: rtl/aes_pkg.sv
// Shared AES loader definitions: key-length header codes, Nk values,
// loader state encoding and the block/key widths.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 256;

    localparam logic [7:0] KLEN_128 = 8'd16;
    localparam logic [7:0] KLEN_192 = 8'd24;
    localparam logic [7:0] KLEN_256 = 8'd32;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_KLEN = 2'd1,
        ST_KEY  = 2'd2,
        ST_HOLD = 2'd3
    } loader_state_e;

    // Returns 0 for any header that is not a legal key length.
    function automatic logic [3:0] nk_from_header(input logic [7:0] hdr);
        case (hdr)
            KLEN_128: return NK_128;
            KLEN_192: return NK_192;
            KLEN_256: return NK_256;
            default:  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_beat_packer.sv
// Byte-offset write of one BEAT_BYTES-wide beat into a byte register with
// synchronous clear; clear wins over a simultaneous write.
module aes_beat_packer
    import aes_pkg::*;
#(
    parameter int BEAT_BYTES = 1,
    parameter int REG_BYTES  = KEY_W / 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [5:0]                offset,
    input  logic [8*BEAT_BYTES-1:0]   beat,
    output logic [8*REG_BYTES-1:0]    value
);

    localparam int IDX_W = $clog2(REG_BYTES);

    logic [8*REG_BYTES-1:0] value_d;
    logic [8*REG_BYTES-1:0] value_q;
    logic [IDX_W-1:0]       byte_idx;

    // Next register contents: clear, beat write, or hold.
    always_comb begin
        value_d  = value_q;
        byte_idx = '0;
        if (clr) begin
            value_d = '0;
        end else if (wr_en) begin
            for (int k = 0; k < BEAT_BYTES; k++) begin
                byte_idx = IDX_W'(offset + 6'(k));
                value_d[{byte_idx, 3'b000} +: 8] = beat[8*k +: 8];
            end
        end else begin
            value_d = value_q;
        end
    end

    // Register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/aes_frame_loader.sv
// Assembles 16 plaintext bytes, a key-length header and 16/24/32 key bytes
// into one frame for the AES core. Optional AES_FRAME_LOADER_KEY_REUSE_EN.
module aes_frame_loader
    import aes_pkg::*;
#(
    parameter int BEAT_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_W-1:0]      out_data,
    output logic [KEY_W-1:0]        out_key,
    output logic [3:0]              out_nk,
    output logic                    err,
    output logic                    busy
);

    localparam int         BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [5:0] DATA_LAST  = 6'(BLOCK_W / 8 / BEAT_BYTES - 1);

    if (!(BEAT_BYTES == 1 || BEAT_BYTES == 2 || BEAT_BYTES == 4 || BEAT_BYTES == 8)) begin : g_bad_beat
        $error("aes_frame_loader: BEAT_BYTES must be 1, 2, 4 or 8");
    end

    loader_state_e state_d, state_q;
    logic [5:0]    cnt_d, cnt_q;
    logic [3:0]    nk_d, nk_q;
    logic          out_valid_d, out_valid_q;
    logic          err_d, err_q;
    logic          in_fire_s;
    logic          data_wr_s;
    logic          key_wr_s;
    logic          key_clr_s;
    logic [3:0]    hdr_nk_s;
    logic [5:0]    key_last_s;
    logic [5:0]    beat_off_s;
`ifdef AES_FRAME_LOADER_KEY_REUSE_EN
    logic          key_loaded_d, key_loaded_q;
`endif

    assign in_ready   = (state_q != ST_HOLD);
    assign in_fire_s  = in_valid && in_ready;
    assign hdr_nk_s   = nk_from_header(in_data[7:0]);
    assign key_last_s = ({nk_q, 2'b00} >> BEAT_SHIFT) - 6'd1;
    assign beat_off_s = cnt_q << BEAT_SHIFT;

    // Next-state, counter and packer-control decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nk_d        = nk_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        data_wr_s   = 1'b0;
        key_wr_s    = 1'b0;
        key_clr_s   = 1'b0;
`ifdef AES_FRAME_LOADER_KEY_REUSE_EN
        key_loaded_d = key_loaded_q;
`endif
        case (state_q)
            ST_DATA: begin
                if (in_fire_s) begin
                    data_wr_s = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = 6'd0;
                        state_d = ST_KLEN;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_KLEN: begin
                if (in_fire_s) begin
                    cnt_d = 6'd0;
                    if (hdr_nk_s != 4'd0) begin
                        nk_d      = hdr_nk_s;
                        key_clr_s = 1'b1;
                        state_d   = ST_KEY;
                    end
`ifdef AES_FRAME_LOADER_KEY_REUSE_EN
                    else if (in_data[7:0] == 8'd0 && key_loaded_q) begin
                        // Previous key and Nk are still held in the output registers.
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
`endif
                    else begin
                        err_d   = 1'b1;
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_KEY: begin
                if (in_fire_s) begin
                    key_wr_s = 1'b1;
                    if (cnt_q == key_last_s) begin
                        cnt_d       = 6'd0;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = 6'd0;
                    state_d     = ST_DATA;
`ifdef AES_FRAME_LOADER_KEY_REUSE_EN
                    key_loaded_d = 1'b1;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                cnt_d       = 6'd0;
                out_valid_d = 1'b0;
                state_d     = ST_DATA;
            end
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_DATA;
            cnt_q       <= 6'd0;
            nk_q        <= NK_128;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef AES_FRAME_LOADER_KEY_REUSE_EN
            key_loaded_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nk_q        <= nk_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
`ifdef AES_FRAME_LOADER_KEY_REUSE_EN
            key_loaded_q <= key_loaded_d;
`endif
        end
    end

    aes_beat_packer #(
        .BEAT_BYTES (BEAT_BYTES),
        .REG_BYTES  (BLOCK_W / 8)
    ) u_data_packer (
        .clk    (clk),
        .reset  (reset),
        .clr    (1'b0),
        .wr_en  (data_wr_s),
        .offset (beat_off_s),
        .beat   (in_data),
        .value  (out_data)
    );

    aes_beat_packer #(
        .BEAT_BYTES (BEAT_BYTES),
        .REG_BYTES  (KEY_W / 8)
    ) u_key_packer (
        .clk    (clk),
        .reset  (reset),
        .clr    (key_clr_s),
        .wr_en  (key_wr_s),
        .offset (beat_off_s),
        .beat   (in_data),
        .value  (out_key)
    );

    assign out_valid = out_valid_q;
    assign out_nk    = nk_q;
    assign err       = err_q;
    assign busy      = !(state_q == ST_DATA && cnt_q == 6'd0);

endmodule

// File: tb/tb_aes_frame_loader.sv
// Directed bench for aes_frame_loader with one BEAT_BYTES=1 and one
// BEAT_BYTES=4 instance; honours AES_FRAME_LOADER_KEY_REUSE_EN.
module tb_aes_frame_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         v1, r1, ov1, or1, err1, busy1;
    logic [7:0]   d1;
    logic [127:0] od1;
    logic [255:0] ok1;
    logic [3:0]   nk1;

    logic         v4, r4, ov4, or4, err4, busy4;
    logic [31:0]  d4;
    logic [127:0] od4;
    logic [255:0] ok4;
    logic [3:0]   nk4;

    int compared   = 0;
    int mismatched = 0;

    aes_frame_loader #(.BEAT_BYTES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_key(ok1),
        .out_nk(nk1), .err(err1), .busy(busy1)
    );

    aes_frame_loader #(.BEAT_BYTES(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .in_data(d4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_key(ok4),
        .out_nk(nk4), .err(err4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] seq(input logic [7:0] base, input int n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    task automatic send1(input logic [7:0] b);
        @(negedge clk);
        v1 = 1'b1;
        d1 = b;
    endtask

    task automatic idle1();
        @(negedge clk);
        v1 = 1'b0;
        d1 = 8'h00;
    endtask

    task automatic frame1(input logic [7:0] dbase, input logic [7:0] hdr,
                          input logic [7:0] kbase, input int nkey);
        for (int i = 0; i < 16; i++) send1(dbase + 8'(i));
        send1(hdr);
        for (int i = 0; i < nkey; i++) send1(kbase + 8'(i));
    endtask

    task automatic accept1();
        @(negedge clk);
        or1 = 1'b1;
        chk("acc_valid_before", 256'(ov1), 256'(1'b1));
        @(negedge clk);
        or1 = 1'b0;
        chk("acc_valid_after", 256'(ov1), 256'(1'b0));
        chk("acc_busy_after", 256'(busy1), 256'(1'b0));
    endtask

    task automatic send4(input logic [31:0] w);
        @(negedge clk);
        v4 = 1'b1;
        d4 = w;
    endtask

    logic [31:0] w;
    logic        early;

    initial begin
        reset = 1'b1;
        v1 = 1'b0; d1 = 8'h00; or1 = 1'b0;
        v4 = 1'b0; d4 = 32'h0; or4 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_in_ready", 256'(r1), 256'(1'b1));
        chk("rst_out_valid", 256'(ov1), 256'(1'b0));
        chk("rst_err", 256'(err1), 256'(1'b0));
        chk("rst_busy", 256'(busy1), 256'(1'b0));
        chk("rst_out_data", 256'(od1), 256'(0));
        chk("rst_out_key", ok1, 256'(0));
        chk("rst_out_nk", 256'(nk1), 256'(4'd4));
        reset = 1'b0;

        // BEAT_BYTES=1, header 16
        frame1(8'h00, 8'd16, 8'h10, 16);
        chk("t1_valid_early", 256'(ov1), 256'(1'b0));
        chk("t1_busy", 256'(busy1), 256'(1'b1));
        idle1();
        chk("t1_valid", 256'(ov1), 256'(1'b1));
        chk("t1_data", 256'(od1), seq(8'h00, 16));
        chk("t1_data_lo", 256'(od1[7:0]), 256'(8'h00));
        chk("t1_data_hi", 256'(od1[127:120]), 256'(8'h0F));
        chk("t1_key", ok1, seq(8'h10, 16));
        chk("t1_nk", 256'(nk1), 256'(4'd4));
        chk("t1_in_ready_hold", 256'(r1), 256'(1'b0));
        accept1();
        chk("t1_in_ready_after", 256'(r1), 256'(1'b1));

        // BEAT_BYTES=4, header 32, back-pressure for 5 cycles
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'hA0 + 8'(4*j + b);
            send4(w);
        end
        send4(32'hFFFF_FF20);
        for (int j = 0; j < 8; j++) begin
            for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'h40 + 8'(4*j + b);
            send4(w);
        end
        chk("t2_valid_early", 256'(ov4), 256'(1'b0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            v4 = 1'b1;
            d4 = 32'hDEAD_BEEF;
            chk("t2_hold_valid", 256'(ov4), 256'(1'b1));
            chk("t2_hold_in_ready", 256'(r4), 256'(1'b0));
            chk("t2_hold_data", 256'(od4), seq(8'hA0, 16));
            chk("t2_hold_key", ok4, seq(8'h40, 32));
            chk("t2_hold_nk", 256'(nk4), 256'(4'd8));
        end
        @(negedge clk);
        or4 = 1'b1;
        chk("t2_acc_valid", 256'(ov4), 256'(1'b1));
        chk("t2_acc_key", ok4, seq(8'h40, 32));
        @(negedge clk);
        or4 = 1'b0;
        v4 = 1'b0;
        chk("t2_post_valid", 256'(ov4), 256'(1'b0));
        chk("t2_post_busy", 256'(busy4), 256'(1'b0));
        chk("t2_post_in_ready", 256'(r4), 256'(1'b1));

        // Illegal header 0x11, then header-24 frame
        frame1(8'h80, 8'h11, 8'h00, 0);
        idle1();
        chk("t3_err", 256'(err1), 256'(1'b1));
        chk("t3_no_valid", 256'(ov1), 256'(1'b0));
        chk("t3_busy", 256'(busy1), 256'(1'b0));
        idle1();
        chk("t3_err_gone", 256'(err1), 256'(1'b0));
        frame1(8'h30, 8'd24, 8'h60, 24);
        idle1();
        chk("t3_valid", 256'(ov1), 256'(1'b1));
        chk("t3_nk", 256'(nk1), 256'(4'd6));
        chk("t3_data", 256'(od1), seq(8'h30, 16));
        chk("t3_key", ok1, seq(8'h60, 24));
        accept1();

        // Same header-24 frame with random in_valid gaps
        early = 1'b0;
        for (int i = 0; i < 41; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                idle1();
                if (ov1) early = 1'b1;
            end
            send1(i < 16 ? 8'h30 + 8'(i) : (i == 16 ? 8'd24 : 8'h60 + 8'(i - 17)));
            if (ov1) early = 1'b1;
        end
        chk("t4_no_early_valid", 256'(early), 256'(1'b0));
        idle1();
        chk("t4_valid", 256'(ov1), 256'(1'b1));
        chk("t4_nk", 256'(nk1), 256'(4'd6));
        chk("t4_data", 256'(od1), seq(8'h30, 16));
        chk("t4_key", ok1, seq(8'h60, 24));
        accept1();

        // Reset after key byte 10 of a header-32 frame
        frame1(8'h90, 8'd32, 8'hE0, 10);
        @(negedge clk);
        v1 = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 256'(ov1), 256'(1'b0));
        chk("t5_rst_err", 256'(err1), 256'(1'b0));
        chk("t5_rst_busy", 256'(busy1), 256'(1'b0));
        chk("t5_rst_data", 256'(od1), 256'(0));
        chk("t5_rst_key", ok1, 256'(0));
        chk("t5_rst_nk", 256'(nk1), 256'(4'd4));
        chk("t5_rst_in_ready", 256'(r1), 256'(1'b1));
        chk("t5_rst_nk4", 256'(nk4), 256'(4'd4));
        @(negedge clk);
        reset = 1'b0;
        idle1();
        chk("t5_no_err_pulse", 256'(err1), 256'(1'b0));

        // Header 0 with no accepted frame since reset is illegal
        frame1(8'h00, 8'h00, 8'h00, 0);
        idle1();
        chk("t6_hdr0_err", 256'(err1), 256'(1'b1));
        chk("t6_hdr0_no_valid", 256'(ov1), 256'(1'b0));
        idle1();

        // Fresh frame A after reset, header 16
        frame1(8'h20, 8'd16, 8'hC0, 16);
        idle1();
        chk("t7_valid", 256'(ov1), 256'(1'b1));
        chk("t7_data", 256'(od1), seq(8'h20, 16));
        chk("t7_key", ok1, seq(8'hC0, 16));
        chk("t7_nk", 256'(nk1), 256'(4'd4));
        accept1();

        // Frame B with header 0
        frame1(8'h50, 8'h00, 8'h00, 0);
        chk("t8_valid_early", 256'(ov1), 256'(1'b0));
        idle1();
`ifdef AES_FRAME_LOADER_KEY_REUSE_EN
        chk("t8_reuse_valid", 256'(ov1), 256'(1'b1));
        chk("t8_reuse_err", 256'(err1), 256'(1'b0));
        chk("t8_reuse_data", 256'(od1), seq(8'h50, 16));
        chk("t8_reuse_key", ok1, seq(8'hC0, 16));
        chk("t8_reuse_nk", 256'(nk1), 256'(4'd4));
        accept1();
`else
        chk("t8_hdr0_err", 256'(err1), 256'(1'b1));
        chk("t8_hdr0_no_valid", 256'(ov1), 256'(1'b0));
        idle1();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
